// File: rtl/ex_fsm_multi.sv
// ex_fsm_multi
//   Multi-channel A/K1/K2 sequence detector. Each channel debounces its level
//   input, follows a high-low-high-low sequence and emits programmable-width
//   K2 (second rising level) and K1 (sequence complete) pulses. Channels are
//   fully independent.
//
//   Optional build macro: EX_FSM_CNT_EN adds a saturating per-channel count of
//   completed sequences (cnt_o) with a synchronous clear (cnt_clr_i).
//
// Ports
//   clk_i      system clock, rising edge
//   rst_i      asynchronous active-high reset
//   a_i        [CH]        per-channel level inputs
//   k1_o       [CH]        K1 pulse, sequence complete
//   k2_o       [CH]        K2 pulse, second rising level seen
//   state_o    [2*CH]      channel n state code at [2n+1:2n]
//   cnt_clr_i              clear all sequence counters   (EX_FSM_CNT_EN only)
//   cnt_o      [CNT_W*CH]  completed-sequence counts      (EX_FSM_CNT_EN only)
//
// State | meaning
// ------+-----------------------------------------------
// IDLE  | waiting for the first high level
// START | first high seen, waiting for it to drop
// STOP  | first low seen, waiting for the second high
// CLEAR | second high seen (K2 fired), waiting for low
module ex_fsm_multi #(
  parameter int unsigned CH         = 2,
  parameter int unsigned DEB_CYCLES = 2,
  parameter int unsigned PULSE_W    = 1,
  parameter int unsigned CNT_W      = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [CH-1:0]     a_i,
  output logic [CH-1:0]     k1_o,
  output logic [CH-1:0]     k2_o,
  output logic [2*CH-1:0]   state_o
`ifdef EX_FSM_CNT_EN
  ,
  input  logic              cnt_clr_i,
  output logic [CNT_W*CH-1:0] cnt_o
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    STOP  = 2'd2,
    CLEAR = 2'd3
  } state_t;

  localparam int unsigned DC_W = $clog2(DEB_CYCLES) + 1;
  localparam int unsigned PC_W = $clog2(PULSE_W) + 1;
  localparam logic [DC_W-1:0] DC_LAST = DC_W'(DEB_CYCLES - 1);
  localparam logic [PC_W-1:0] PC_LOAD = PC_W'(PULSE_W - 1);

  if (CH < 1 || CH > 32 || DEB_CYCLES < 1 || PULSE_W < 1 || CNT_W < 1) begin : g_param_check
    $error("ex_fsm_multi: illegal parameter value");
  end

  for (genvar ch = 0; ch < CH; ch++) begin : g_ch
    logic            a_f_q, a_f_d;
    logic [DC_W-1:0] dc_q, dc_d;
    state_t          state_q, state_d;
    logic            fire_k1, fire_k2;
    logic            k1_q, k1_d, k2_q, k2_d;
    // Remaining high cycles after the current one; terminal count is zero.
    logic [PC_W-1:0] k1_left_q, k1_left_d, k2_left_q, k2_left_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        a_f_q     <= 1'b0;
        dc_q      <= '0;
        state_q   <= IDLE;
        k1_q      <= 1'b0;
        k2_q      <= 1'b0;
        k1_left_q <= '0;
        k2_left_q <= '0;
      end else begin
        a_f_q     <= a_f_d;
        dc_q      <= dc_d;
        state_q   <= state_d;
        k1_q      <= k1_d;
        k2_q      <= k2_d;
        k1_left_q <= k1_left_d;
        k2_left_q <= k2_left_d;
      end
    end

    // Filter follows the input only after it has differed for DEB_CYCLES edges.
    always_comb begin
      a_f_d = a_f_q;
      dc_d  = '0;
      if (a_i[ch] != a_f_q) begin
        if (dc_q == DC_LAST) begin
          a_f_d = a_i[ch];
        end else begin
          dc_d = dc_q + 1'b1;
        end
      end
    end

    always_comb begin
      state_d = state_q;
      fire_k1 = 1'b0;
      fire_k2 = 1'b0;
      case (state_q)
        IDLE:  if (a_f_q)  state_d = START;
        START: if (!a_f_q) state_d = STOP;
        STOP:  if (a_f_q) begin
                 state_d = CLEAR;
                 fire_k2 = 1'b1;
               end
        CLEAR: if (!a_f_q) begin
                 state_d = IDLE;
                 fire_k1 = 1'b1;
               end
        default: state_d = IDLE;
      endcase
    end

    // A firing reloads the down-counter, so a retrigger extends the pulse.
    always_comb begin
      k1_d      = k1_q;
      k1_left_d = k1_left_q;
      k2_d      = k2_q;
      k2_left_d = k2_left_q;
      if (fire_k1) begin
        k1_d      = 1'b1;
        k1_left_d = PC_LOAD;
      end else if (k1_q) begin
        if (k1_left_q == '0) k1_d = 1'b0;
        else                 k1_left_d = k1_left_q - 1'b1;
      end
      if (fire_k2) begin
        k2_d      = 1'b1;
        k2_left_d = PC_LOAD;
      end else if (k2_q) begin
        if (k2_left_q == '0) k2_d = 1'b0;
        else                 k2_left_d = k2_left_q - 1'b1;
      end
    end

    assign k1_o[ch]           = k1_q;
    assign k2_o[ch]           = k2_q;
    assign state_o[2*ch +: 2] = state_q;

`ifdef EX_FSM_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear wins over a same-edge increment; the count saturates.
    always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr_i) begin
        cnt_d = '0;
      end else if (fire_k1 && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
    end

    assign cnt_o[CNT_W*ch +: CNT_W] = cnt_q;
`endif
  end

endmodule

// File: doc/ex_fsm_multi.md
Name: ex_fsm_multi

Overview:
- Parametrised, multi-channel successor of the single-input A/K1/K2 sequence FSM.
- Each of CH independent channels:
  - debounces its input a_i[ch];
  - tracks the high-low-high-low sequence with a four-state machine;
  - emits K2 and K1 pulses of programmable width.
- Sits between raw button/level inputs and downstream control logic, replacing per-channel single-FSM instances.

Parameters:
- CH, 2, number of independent channels (1..32).
- DEB_CYCLES, 2, consecutive cycles a_i must differ from its filtered value before the filter updates (>=1).
- PULSE_W, 1, width in clk_i cycles of each K1/K2 pulse (>=1).
- CNT_W, 8, width of the per-channel sequence counter (used only with the optional feature).

Ports:
- clk_i  input  1  system clock, all logic on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- a_i  input  CH  per-channel level inputs, synchronous to clk_i.
- k1_o  output  CH  per-channel K1 pulse (sequence complete).
- k2_o  output  CH  per-channel K2 pulse (second rising level seen).
- state_o  output  2*CH  per-channel state code, channel n at bits [2n+1:2n].
- cnt_o  output  CNT_W*CH  per-channel completed-sequence count; present only with EX_FSM_CNT_EN.
- cnt_clr_i  input  1  synchronous clear of all counters; present only with EX_FSM_CNT_EN.

Behaviour:
Reset:
- rst_i=1 immediately forces every channel to: a_f=0, debounce count=0, state=IDLE, pulse counters=0, k1_o=0, k2_o=0, cnt_o=0.
- Asserting rst_i mid-sequence or mid-pulse aborts it with no further pulse.

Debounce filter (per channel):
- Register a_f and counter dc (width clog2(DEB_CYCLES)+1).
- When a_i==a_f: dc<=0.
- When a_i!=a_f and dc==DEB_CYCLES-1: a_f<=a_i and dc<=0.
- Otherwise: dc<=dc+1.
- A glitch shorter than DEB_CYCLES sampled edges is discarded.

State machine (per channel, encoding IDLE=0, START=1, STOP=2, CLEAR=3):
- IDLE  -> START  when a_f=1.
- START -> STOP   when a_f=0.
- STOP  -> CLEAR  when a_f=1; fires K2.
- CLEAR -> IDLE   when a_f=0; fires K1.
- In all other cases the state holds.

Pulse generator:
- On a firing transition, the output is registered high on the same edge as the state change and stays high for exactly PULSE_W cycles.
- A new firing on the same output while a pulse is active restarts the PULSE_W count. The pulse is extended, not doubled.
- K1 and K2 pulses are independent and may overlap when PULSE_W is large.

Latency:
- Let e0 be the first edge sampling the new a_i value.
- a_f updates at edge e(DEB_CYCLES-1).
- The state change and pulse rise occur at edge e(DEB_CYCLES).
- With the defaults, the pulse is high after the 3rd sampling edge.

Channel independence:
- Channels share no state.
- Simultaneous events on several channels are all processed in the same cycle.

Optional Feature:
- Macro: EX_FSM_CNT_EN.
- Defined:
  - Each channel has a CNT_W-bit counter that increments on every CLEAR->IDLE transition, i.e. the same edge K1 fires.
  - The counter saturates at 2^CNT_W-1 and does not wrap.
  - cnt_clr_i=1 zeroes all counters at the next edge and takes priority over a simultaneous increment.
  - cnt_o and cnt_clr_i ports exist.
- Not defined: no counters, and neither the cnt_o nor the cnt_clr_i port exists. All other behaviour is identical.

Test Plan:
1. Reset check: hold rst_i=1 with a_i=2'b11 for 10 cycles -> k1_o=k2_o=0, state_o=0, cnt_o=0. Then release; after a_i stays 1 for 3 edges -> both states = START.
2. Full sequence, channel 0, defaults: a_i[0] = 1, 0, 1, 0, each held 6 cycles.
   - Required: k2_o[0] high exactly 1 cycle, 3 edges after the second rise.
   - Required: k1_o[0] high exactly 1 cycle, 3 edges after the second fall.
   - Required: channel 1 shows no activity.
3. Glitch rejection: in IDLE, a_i[1]=1 for 1 cycle then 0 -> state stays IDLE and no pulse. A 2-cycle high -> START.
4. Pulse width and retrigger: PULSE_W=4, DEB_CYCLES=1, ch0 in STOP.
   - Toggle a_i 1->0 within 2 cycles to fire K2 then K1 -> k2_o high 4 cycles.
   - Fire again 2 cycles into an active pulse -> one continuous high of 6 cycles.
5. Parallel channels and reset mid-operation: both channels run the sequence in lockstep -> k1_o=2'b11 on the same cycle. Assert rst_i while k2_o is high -> k2_o drops immediately and no K1 follows.
6. EX_FSM_CNT_EN: CNT_W=2, run 5 sequences -> cnt_o[ch0] = 1, 2, 3, 3, 3. Assert cnt_clr_i on the same edge as a K1 -> count 0.
